// File: rtl/xcr_int_sequencer.sv
// Interrupt entry/exit sequencer: fixed-priority cause arbitration, vector address
// generation, request/ack handshake with the core and one-shot w1c clear pulses.
module xcr_int_sequencer #(
  parameter int NSRC          = 8,
  parameter int VEC_MIN_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] xcp_pend,
  input  logic [NSRC-1:0] int_pend,
  input  logic            int_en,
  input  logic [23:0]     ivt_base,
  input  logic [1:0]      ivesiz,
  output logic            irq_req,
  input  logic            irq_ack,
  input  logic            iret,
  output logic [23:0]     ivec_addr,
  output logic [7:0]      mcause,
  output logic [NSRC-1:0] clr_xcp,
  output logic [NSRC-1:0] clr_int,
  output logic            in_service
);

  localparam int IW = $clog2(2 * NSRC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACTIVE
  } state_t;

  state_t          state_q, state_d;
  logic            is_int_q, is_int_d;
  logic [NSRC-1:0] onehot_q, onehot_d;
  logic [23:0]     ivec_addr_q, ivec_addr_d;
  logic [7:0]      mcause_q, mcause_d;
  logic [NSRC-1:0] clr_xcp_q, clr_xcp_d;
  logic [NSRC-1:0] clr_int_q, clr_int_d;

  logic            xcp_any;
  logic            int_any;
  logic [IW-1:0]   xcp_idx;
  logic [IW-1:0]   int_idx;
  logic [NSRC-1:0] xcp_oh;
  logic [NSRC-1:0] int_oh;
  logic [IW-1:0]   arb_idx;
  logic [4:0]      shamt;
  logic [23:0]     arb_addr;

  // Scanning from the top down leaves the lowest set bit as the winner.
  always_comb begin
    xcp_idx = '0;
    int_idx = '0;
    xcp_oh  = '0;
    int_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (xcp_pend[i]) begin
        xcp_idx = IW'(i);
        xcp_oh  = NSRC'(1) << i;
      end
      if (int_pend[i]) begin
        int_idx = IW'(NSRC + i);
        int_oh  = NSRC'(1) << i;
      end
    end
  end

  assign xcp_any  = |xcp_pend;
  assign int_any  = int_en && (|int_pend);
  assign arb_idx  = xcp_any ? xcp_idx : int_idx;
  assign shamt    = 5'(VEC_MIN_SHIFT) + {3'b000, ivesiz};
  assign arb_addr = ivt_base + (24'(arb_idx) << shamt);

  always_comb begin
    state_d     = state_q;
    is_int_d    = is_int_q;
    onehot_d    = onehot_q;
    ivec_addr_d = ivec_addr_q;
    mcause_d    = mcause_q;
    clr_xcp_d   = '0;
    clr_int_d   = '0;

    case (state_q)
      IDLE: begin
        if (xcp_any || int_any) begin
          is_int_d    = !xcp_any;
          onehot_d    = xcp_any ? xcp_oh : int_oh;
          ivec_addr_d = arb_addr;
          mcause_d    = {!xcp_any, 7'(arb_idx)};
          state_d     = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over an interrupt cancel in the same cycle.
        if (irq_ack) begin
          if (is_int_q) clr_int_d = onehot_q;
          else          clr_xcp_d = onehot_q;
          state_d = ACTIVE;
        end else if (is_int_q && !int_en) begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (iret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_int_q    <= 1'b0;
      onehot_q    <= '0;
      ivec_addr_q <= '0;
      mcause_q    <= '0;
      clr_xcp_q   <= '0;
      clr_int_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_int_q    <= is_int_d;
      onehot_q    <= onehot_d;
      ivec_addr_q <= ivec_addr_d;
      mcause_q    <= mcause_d;
      clr_xcp_q   <= clr_xcp_d;
      clr_int_q   <= clr_int_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == ACTIVE);
  assign ivec_addr  = ivec_addr_q;
  assign mcause     = mcause_q;
  assign clr_xcp    = clr_xcp_q;
  assign clr_int    = clr_int_q;

endmodule

// File: tb/tb_xcr_int_sequencer.sv
// Bench for xcr_int_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_xcr_int_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  xcp_pend = '0;
  logic [7:0]  int_pend = '0;
  logic        int_en = 1'b0;
  logic [23:0] ivt_base = '0;
  logic [1:0]  ivesiz = '0;
  logic        irq_req;
  logic        irq_ack = 1'b0;
  logic        iret = 1'b0;
  logic [23:0] ivec_addr;
  logic [7:0]  mcause;
  logic [7:0]  clr_xcp;
  logic [7:0]  clr_int;
  logic        in_service;

  int n_checks = 0;
  int n_pass   = 0;

  xcr_int_sequencer #(.NSRC(8), .VEC_MIN_SHIFT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xcp_pend   (xcp_pend),
    .int_pend   (int_pend),
    .int_en     (int_en),
    .ivt_base   (ivt_base),
    .ivesiz     (ivesiz),
    .irq_req    (irq_req),
    .irq_ack    (irq_ack),
    .iret       (iret),
    .ivec_addr  (ivec_addr),
    .mcause     (mcause),
    .clr_xcp    (clr_xcp),
    .clr_int    (clr_int),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: a cause is either waiting for ack, being serviced, or absent.
  logic        m_waiting, m_serving, m_is_int;
  logic [7:0]  m_bit, m_clr_x, m_clr_i, m_mcause;
  logic [23:0] m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_waiting = 0; m_serving = 0; m_is_int = 0;
      m_bit = 0; m_clr_x = 0; m_clr_i = 0; m_mcause = 0; m_addr = 0;
    end else begin
      m_clr_x = 0;
      m_clr_i = 0;
      if (!m_waiting && !m_serving) begin
        int idx;
        idx = -1;
        for (int k = 0; k < 8; k++)
          if (idx < 0 && xcp_pend[k]) idx = k;
        if (idx < 0 && int_en)
          for (int k = 0; k < 8; k++)
            if (idx < 0 && int_pend[k]) idx = 8 + k;
        if (idx >= 0) begin
          m_waiting = 1;
          m_is_int  = (idx >= 8);
          m_bit     = 8'(1 << (idx % 8));
          m_mcause  = 8'((m_is_int ? 128 : 0) + idx);
          m_addr    = 24'((int'(ivt_base) + idx * (4 << ivesiz)) % (1 << 24));
        end
      end else if (m_waiting) begin
        if (irq_ack) begin
          m_waiting = 0;
          m_serving = 1;
          if (m_is_int) m_clr_i = m_bit;
          else          m_clr_x = m_bit;
        end else if (m_is_int && !int_en) begin
          m_waiting = 0;
        end
      end else if (iret) begin
        m_serving = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("irq_req",    32'(irq_req),    32'(m_waiting));
    chk("in_service", 32'(in_service), 32'(m_serving));
    chk("clr_xcp",    32'(clr_xcp),    32'(m_clr_x));
    chk("clr_int",    32'(clr_int),    32'(m_clr_i));
    chk("ivec_addr",  32'(ivec_addr),  32'(m_addr));
    chk("mcause",     32'(mcause),     32'(m_mcause));
  end

  // Advance to just after the next edge; outputs are settled, inputs may change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic iret_pulse();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  initial begin
    // Reset with an exception held pending.
    xcp_pend = 8'h01;
    ivt_base = 24'h123456;
    #2;
    repeat (3) tick();
    chk("d_rst_req", 32'(irq_req), 32'h0);
    chk("d_rst_mcause", 32'(mcause), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("d_first_req", 32'(irq_req), 32'h1);
    chk("d_first_mcause", 32'(mcause), 32'h00);
    chk("d_first_addr", 32'(ivec_addr), 32'h123456);
    ack_pulse();
    xcp_pend = 8'h00;
    chk("d_first_clr", 32'(clr_xcp), 32'h01);
    chk("d_first_insvc", 32'(in_service), 32'h1);
    iret_pulse();
    chk("d_first_iret", 32'(in_service), 32'h0);

    // Interrupt path with 8-byte slots.
    int_en = 1'b1; int_pend = 8'h0C; ivt_base = 24'h001000; ivesiz = 2'd1;
    tick();
    chk("d_int_mcause", 32'(mcause), 32'h8A);
    chk("d_int_addr", 32'(ivec_addr), 32'h001050);
    ack_pulse();
    chk("d_int_clr", 32'(clr_int), 32'h04);
    int_pend = 8'h08;
    tick();
    chk("d_int_clr_once", 32'(clr_int), 32'h00);
    chk("d_int_insvc", 32'(in_service), 32'h1);
    int_pend = 8'h00;
    iret_pulse();
    chk("d_int_iret", 32'(in_service), 32'h0);

    // Exception beats interrupt; the interrupt follows after iret.
    xcp_pend = 8'h80; int_pend = 8'h01;
    tick();
    chk("d_prio_mcause", 32'(mcause), 32'h07);
    ack_pulse();
    xcp_pend = 8'h00;
    tick();
    iret_pulse();
    tick();
    chk("d_prio_next_req", 32'(irq_req), 32'h1);
    chk("d_prio_next_mcause", 32'(mcause), 32'h88);
    ack_pulse();
    int_pend = 8'h00;
    iret_pulse();

    // Interrupts masked, then cancelled while requesting.
    int_en = 1'b0; int_pend = 8'hFF;
    tick(); tick();
    chk("d_mask_req", 32'(irq_req), 32'h0);
    int_en = 1'b1;
    tick();
    chk("d_cancel_req_up", 32'(irq_req), 32'h1);
    int_en = 1'b0;
    tick();
    chk("d_cancel_req_down", 32'(irq_req), 32'h0);
    chk("d_cancel_noclr", 32'(clr_int), 32'h00);
    tick();
    chk("d_cancel_idle", 32'(irq_req | in_service), 32'h0);
    int_pend = 8'h00;

    // Vector address wraps at 24 bits.
    ivt_base = 24'hFFFFF0; ivesiz = 2'd3; xcp_pend = 8'h08;
    tick();
    chk("d_wrap_addr", 32'(ivec_addr), 32'h000050);
    ack_pulse();
    xcp_pend = 8'h00;
    chk("d_wrap_clr", 32'(clr_xcp), 32'h08);

    // New pending and spurious ack while serving are ignored.
    xcp_pend = 8'h02; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("d_active_noreq", 32'(irq_req), 32'h0);
    chk("d_active_noclr", 32'(clr_xcp), 32'h00);
    iret_pulse();
    chk("d_after_iret_idle", 32'(irq_req), 32'h0);
    tick();
    chk("d_after_iret_req", 32'(irq_req), 32'h1);
    chk("d_after_iret_mcause", 32'(mcause), 32'h01);
    ack_pulse();
    xcp_pend = 8'h00;
    iret_pulse();

    // Randomized traffic with w1c emulation of the pending registers.
    for (int c = 0; c < 3000; c++) begin
      xcp_pend = xcp_pend & ~clr_xcp;
      int_pend = int_pend & ~clr_int;
      if ($urandom_range(0, 11) == 0) xcp_pend = xcp_pend | 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0)  int_pend = int_pend | 8'($urandom & $urandom);
      if ($urandom_range(0, 5) == 0)  xcp_pend = xcp_pend & 8'($urandom);
      if ($urandom_range(0, 9) == 0)  int_en = ~int_en;
      if ($urandom_range(0, 15) == 0) ivt_base = 24'($urandom);
      if ($urandom_range(0, 7) == 0)  ivesiz = 2'($urandom);
      irq_ack = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      iret    = in_service ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      if (c == 1500 || c == 2400) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    irq_ack = 1'b0;
    iret = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
